// File: rtl/eth_tx_pkg.sv
// Shared types and constants for the RGMII transmit scheduler.
package eth_tx_pkg;

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, IFG} tx_state_t;

  localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0]  SFD_BYTE        = 8'hD5;
  localparam int unsigned PREAMBLE_LEN    = 7;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 next-state logic; the register lives in the caller.
module crc32_d8
  import eth_tx_pkg::*;
(
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  always_comb begin
    crc_next = crc ^ {24'h000000, data};
    for (int unsigned b = 0; b < 8; b++) begin
      crc_next = crc_next[0] ? ((crc_next >> 1) ^ CRC32_POLY_REFL) : (crc_next >> 1);
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Round-robin frame scheduler for the RGMII TX byte path: preamble/SFD, padding, IFG.
// Define ETH_TX_FCS_EN to append a CRC-32 FCS after payload+pad.
module eth_tx_sched
  import eth_tx_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int IFG_BYTES   = 12,
  parameter int MIN_PAYLOAD = 60
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [8*N_REQ-1:0]   i_data,
  input  logic [N_REQ-1:0]     i_valid,
  input  logic [N_REQ-1:0]     i_last,
  output logic [N_REQ-1:0]     o_ready,
  output logic [N_REQ-1:0]     o_grant,
  output logic [7:0]           o_byte,
  output logic                 o_en,
  output logic                 o_underrun,
  output logic                 o_busy
);

  localparam int unsigned NR    = N_REQ;
  localparam int unsigned PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [15:0] MIN_P = 16'(MIN_PAYLOAD);
  localparam logic [15:0] IFG_N = 16'(IFG_BYTES);

`ifdef ETH_TX_FCS_EN
  localparam tx_state_t TAIL = FCS;
`else
  localparam tx_state_t TAIL = IFG;
`endif

  tx_state_t   state;
  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] pick_idx;
  logic [PW-1:0] cand;
  logic          pick_found;
  logic [2:0]    pre_cnt;
  logic [15:0]   pay_cnt;
  logic [15:0]   pay_inc;
  logic [15:0]   ifg_cnt;
  logic [7:0]    g_data;
  logic          g_valid;
  logic          g_last;

`ifdef ETH_TX_FCS_EN
  logic [31:0] crc;
  logic [31:0] crc_nxt;
  logic [1:0]  fcs_idx;

  crc32_d8 u_crc (
    .crc      (crc),
    .data     ((state == PAD) ? 8'h00 : g_data),
    .crc_next (crc_nxt)
  );
`endif

  assign g_data  = i_data[8*gidx +: 8];
  assign g_valid = i_valid[gidx];
  assign g_last  = i_last[gidx];
  assign pay_inc = sat_inc16(pay_cnt);
  assign o_ready = o_grant & {N_REQ{(state == SFD) || (state == DATA)}};
  assign o_busy  = (state != IDLE);

  // First pending requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      cand = PW'((32'(rr_ptr) + i) % NR);
      if (!pick_found && i_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // State tracks the byte currently on o_byte; SFD/DATA accept the next payload byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= IDLE;
      o_byte     <= '0;
      o_en       <= 1'b0;
      o_grant    <= '0;
      o_underrun <= 1'b0;
      rr_ptr     <= '0;
      gidx       <= '0;
      pre_cnt    <= '0;
      pay_cnt    <= '0;
      ifg_cnt    <= '0;
`ifdef ETH_TX_FCS_EN
      crc        <= CRC32_INIT;
      fcs_idx    <= '0;
`endif
    end else begin
      o_underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state   <= PRE;
            o_byte  <= PREAMBLE_BYTE;
            o_en    <= 1'b1;
            o_grant <= N_REQ'(1) << pick_idx;
            gidx    <= pick_idx;
            rr_ptr  <= PW'((32'(pick_idx) + 1) % NR);
            pre_cnt <= 3'd1;
            pay_cnt <= '0;
`ifdef ETH_TX_FCS_EN
            crc     <= CRC32_INIT;
`endif
          end
        end
        PRE: begin
          if (pre_cnt == 3'(PREAMBLE_LEN)) begin
            state  <= SFD;
            o_byte <= SFD_BYTE;
          end else begin
            o_byte  <= PREAMBLE_BYTE;
            pre_cnt <= pre_cnt + 3'd1;
          end
        end
        SFD, DATA: begin
          if (g_valid) begin
            o_byte  <= g_data;
            pay_cnt <= pay_inc;
            ifg_cnt <= '0;
`ifdef ETH_TX_FCS_EN
            crc     <= crc_nxt;
            fcs_idx <= '0;
`endif
            if (!g_last)             state <= DATA;
            else if (pay_inc < MIN_P) state <= PAD;
            else                      state <= TAIL;
          end else begin
            // Starved: abandon the frame, en already low so IFG count starts at 1.
            o_underrun <= 1'b1;
            o_en       <= 1'b0;
            o_byte     <= '0;
            o_grant    <= '0;
            ifg_cnt    <= 16'd1;
            state      <= IFG;
          end
        end
        PAD: begin
          o_byte  <= '0;
          pay_cnt <= pay_inc;
`ifdef ETH_TX_FCS_EN
          crc     <= crc_nxt;
`endif
          if (pay_inc >= MIN_P) state <= TAIL;
        end
`ifdef ETH_TX_FCS_EN
        FCS: begin
          o_byte  <= ~crc[7:0];
          crc     <= {8'h00, crc[31:8]};
          fcs_idx <= fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) state <= IFG;
        end
`endif
        IFG: begin
          o_en    <= 1'b0;
          o_byte  <= '0;
          o_grant <= '0;
          if (ifg_cnt == IFG_N) state <= IDLE;
          else                  ifg_cnt <= ifg_cnt + 16'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/eth_tx_sched.md
# eth_tx_sched

Frame scheduler for the RGMII transmit byte path. Arbitrates round-robin between N frame requesters and wraps the granted payload stream in preamble/SFD, minimum-length padding and optional FCS. Drives the byte/enable pair that feeds the per-lane oddr stage, and enforces the inter-frame gap. Sits between the packet sources (ICMP responder, UART bridge) and the DDR output stage, clocked from the 125 MHz ETH_RXCLK.

## Interface
- N_REQ, 2, number of requesters (1..8)
- IFG_BYTES, 12, idle byte-times between frames (>=1)
- MIN_PAYLOAD, 60, payload padded with 0x00 up to this length (0 = no padding)
- i_clk  in  1  125 MHz byte clock
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  N_REQ  requester has a frame pending; held until its last byte is accepted
- i_data  in  8*N_REQ  payload byte, requester k at [8k+7:8k]
- i_valid  in  N_REQ  i_data valid
- i_last  in  N_REQ  current byte is the final payload byte
- o_ready  out  N_REQ  byte accepted on this edge when valid&ready
- o_grant  out  N_REQ  one-hot, current owner
- o_byte  out  8  byte to DDR stage (low nibble on rising edge)
- o_en  out  1  TXCTRL, high for every preamble/SFD/payload/pad/FCS byte
- o_underrun  out  1  one-cycle pulse, payload stream starved
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, PRE, SFD, DATA, PAD, FCS, IFG. States name the byte being loaded into o_byte.
- IDLE: if any i_req, pick the first set bit at or after rr_ptr (wrapping); set o_grant, go to PRE; rr_ptr <= grantee+1 mod N_REQ.
- PRE: 7 bytes 0x55. SFD: 1 byte 0xD5.
- o_ready[g] = o_grant[g] && (state==SFD || state==DATA). A byte accepted on edge t is on o_byte after t.
- DATA: on accepted i_last: if payload count < MIN_PAYLOAD go to PAD, else go to FCS (FCS_EN) or IFG.
- DATA, grantee i_valid low: underrun. o_underrun pulses, o_en <= 0, o_grant cleared, go to IFG. No FCS, no padding.
- PAD: emit 0x00 until count == MIN_PAYLOAD. Payload counter is 16 bits and saturates.
- IFG: o_en=0, o_byte=0x00 for IFG_BYTES cycles, o_grant cleared, then IDLE. Requests arriving here wait.
- Reset values: o_en=0, o_byte=0x00, o_grant=0, o_ready=0, o_underrun=0, o_busy=0, rr_ptr=0, state IDLE. Reset mid-frame truncates with no FCS; o_en is low after the reset edge.

## Timing
- i_req seen in IDLE at edge t: first 0x55 with o_en=1 after t, and o_grant valid in the same cycle.
- Preamble occupies o_en cycles 0..6, SFD cycle 7, first payload byte cycle 8, then contiguous.
- Frame o_en high time is 8 + max(len, MIN_PAYLOAD), plus 4 with FCS_EN.
- After the last o_en-high cycle, o_en is low for exactly IFG_BYTES cycles, then an IDLE cycle.
- Minimum o_en-low gap between back-to-back frames is IFG_BYTES+1.
- Only the grantee sees o_ready. i_valid/i_data of non-grantees are ignored.

## Configuration
- ETH_TX_FCS_EN defined: append CRC-32 over payload+pad.
  - Reflected poly 0xEDB88320, init 0xFFFFFFFF, final complement.
  - 4 bytes sent least-significant byte first in state FCS.
- ETH_TX_FCS_EN undefined: no CRC logic; DATA/PAD go straight to IFG. The requester supplies the FCS inside its payload.

## Structure
- Package eth_tx_pkg holds:
  - state enum
  - PREAMBLE_BYTE 8'h55, SFD_BYTE 8'hD5, PREAMBLE_LEN 7
  - CRC32_POLY_REFL 32'hEDB88320, CRC32_INIT 32'hFFFFFFFF
- Sub-module crc32_d8: byte-wide combinational CRC next-state, with the register kept in the scheduler. Instantiated only under ETH_TX_FCS_EN.

## Test plan
- FCS known value: ETH_TX_FCS_EN, MIN_PAYLOAD=0, req0 sends ASCII "123456789" -> o_byte is 55×7, D5, 31..39, then 26 39 F4 CB; o_en high for 21 cycles.
- Padding: MIN_PAYLOAD=60, no FCS, 10-byte payload 0x01..0x0A -> 50 bytes of 0x00 follow; o_en high for 68 cycles, then low for 12.
- Arbitration: i_req=2'b11 held from reset, 2-byte frames -> grants alternate 0,1,0,1; each o_en-low gap is exactly 13 cycles.
- Underrun: i_valid drops after payload byte 5 -> o_underrun pulses once, o_en low on the next cycle, 12-cycle IFG follows, and the next grant goes to the other requester.
- Reset mid-DATA: i_rst for 1 cycle -> o_en=0, o_grant=0 after the edge; a following req0 restarts from a fresh preamble with rr_ptr=0.
- Back-pressure isolation: requester 1 asserts i_valid while requester 0 owns the bus -> o_ready[1] stays 0 and requester 1's bytes never appear on o_byte.
